// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction read, data read/write) arbiter onto one physical memory port, one transaction in flight
module mem_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read,
  input  logic [15:0] i_address,
  output logic        i_resp,
  output logic [15:0] i_rdata,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [15:0] d_address,
  input  logic [15:0] d_wdata,
  input  logic [1:0]  d_byte_enable,
  output logic        d_resp,
  output logic [15:0] d_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic [1:0]  pmem_byte_enable,
  input  logic        pmem_resp,
  input  logic [15:0] pmem_rdata
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state_q, state_d;
  logic last_d_q, last_d_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0] be_q, be_d;
  logic we_q, we_d;
  logic i_req, d_req, grant_d, serving, done;
  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign grant_d = d_req & (~i_req | ~FAIR | ~last_d_q);
  assign serving = state_q != IDLE;
  assign done = serving & pmem_resp;
  always_comb begin
    state_d = state_q;
    last_d_d = last_d_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    be_d = be_q;
    we_d = we_q;
    if (state_q == IDLE && (i_req | d_req)) begin
      state_d = grant_d ? SERVE_D : SERVE_I;
      last_d_d = grant_d;
      addr_d = grant_d ? d_address : i_address;
      wdata_d = grant_d ? d_wdata : 16'h0000;
      be_d = grant_d ? d_byte_enable : 2'b11;
      we_d = grant_d & d_write;
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_d_q <= 1'b1;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_d_q <= last_d_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      we_q <= we_d;
    end
  end
  assign pmem_read = ~rst & serving & ~we_q;
  assign pmem_write = ~rst & serving & we_q;
  assign pmem_address = addr_q;
  assign pmem_wdata = wdata_q;
  assign pmem_byte_enable = be_q;
  assign i_resp = ~rst & done & (state_q == SERVE_I);
  assign d_resp = ~rst & done & (state_q == SERVE_D);
  assign i_rdata = i_resp ? pmem_rdata : 16'h0000;
  assign d_rdata = d_resp ? pmem_rdata : 16'h0000;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of round-robin and fixed-priority arbiters against a transaction model
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst, i_read, d_read, d_write, pmem_resp;
  logic [15:0] i_address, d_address, d_wdata, pmem_rdata;
  logic [1:0] d_byte_enable;
  logic [1:0] i_resp_w, d_resp_w, prd_w, pwr_w;
  logic [15:0] i_rdata_w [2];
  logic [15:0] d_rdata_w [2];
  logic [15:0] pa_w [2];
  logic [15:0] pwd_w [2];
  logic [1:0] pbe_w [2];
  int checks = 0;
  int errors = 0;
  bit fair [2] = '{1'b1, 1'b0};
  bit m_busy [2];
  bit m_port_d [2];
  bit m_last_d [2];
  bit m_wr [2];
  logic [15:0] m_addr [2];
  logic [15:0] m_wd [2];
  logic [1:0] m_be [2];
  bit e_ir [2];
  bit e_dr [2];
  always #5 clk = ~clk;
  mem_arbiter #(.FAIR(1'b1)) u_rr (
    .clk(clk), .rst(rst), .i_read(i_read), .i_address(i_address),
    .i_resp(i_resp_w[0]), .i_rdata(i_rdata_w[0]),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp_w[0]), .d_rdata(d_rdata_w[0]),
    .pmem_read(prd_w[0]), .pmem_write(pwr_w[0]), .pmem_address(pa_w[0]),
    .pmem_wdata(pwd_w[0]), .pmem_byte_enable(pbe_w[0]),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );
  mem_arbiter #(.FAIR(1'b0)) u_fix (
    .clk(clk), .rst(rst), .i_read(i_read), .i_address(i_address),
    .i_resp(i_resp_w[1]), .i_rdata(i_rdata_w[1]),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_byte_enable(d_byte_enable), .d_resp(d_resp_w[1]), .d_rdata(d_rdata_w[1]),
    .pmem_read(prd_w[1]), .pmem_write(pwr_w[1]), .pmem_address(pa_w[1]),
    .pmem_wdata(pwd_w[1]), .pmem_byte_enable(pbe_w[1]),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit ir, input bit dr, input bit dw,
                      input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                      input logic [1:0] be, input bit pr, input logic [15:0] prd);
    bit act, win_d;
    rst = r; i_read = ir; d_read = dr; d_write = dw;
    i_address = ia; d_address = da; d_wdata = wd; d_byte_enable = be;
    pmem_resp = pr; pmem_rdata = prd;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      act = !r && m_busy[k];
      e_ir[k] = act && !m_port_d[k] && pr;
      e_dr[k] = act && m_port_d[k] && pr;
      check($sformatf("pmem_read%0d", k), 32'(prd_w[k]), 32'(act && !m_wr[k]));
      check($sformatf("pmem_write%0d", k), 32'(pwr_w[k]), 32'(act && m_wr[k]));
      check($sformatf("i_resp%0d", k), 32'(i_resp_w[k]), 32'(e_ir[k]));
      check($sformatf("d_resp%0d", k), 32'(d_resp_w[k]), 32'(e_dr[k]));
      check($sformatf("i_rdata%0d", k), 32'(i_rdata_w[k]), 32'(e_ir[k] ? prd : 16'h0000));
      check($sformatf("d_rdata%0d", k), 32'(d_rdata_w[k]), 32'(e_dr[k] ? prd : 16'h0000));
      if (act) begin
        check($sformatf("pmem_address%0d", k), 32'(pa_w[k]), 32'(m_addr[k]));
        check($sformatf("pmem_wdata%0d", k), 32'(pwd_w[k]), 32'(m_wd[k]));
        check($sformatf("pmem_be%0d", k), 32'(pbe_w[k]), 32'(m_be[k]));
      end
      if (r) begin
        m_busy[k] = 1'b0;
        m_last_d[k] = 1'b1;
      end else if (m_busy[k]) begin
        if (pr) m_busy[k] = 1'b0;
      end else if (ir || dr || dw) begin
        if (!(dr || dw)) win_d = 1'b0;
        else if (!ir) win_d = 1'b1;
        else win_d = fair[k] ? !m_last_d[k] : 1'b1;
        m_busy[k] = 1'b1;
        m_port_d[k] = win_d;
        m_last_d[k] = win_d;
        m_wr[k] = win_d && dw;
        m_addr[k] = win_d ? da : ia;
        m_wd[k] = win_d ? wd : 16'h0000;
        m_be[k] = win_d ? be : 2'b11;
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    bit ia_act, da_act, d_r, d_w;
    rst = 1'b1; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_address = 0; d_address = 0; d_wdata = 0; d_byte_enable = 0; pmem_rdata = 0;
    @(posedge clk);
    #1;
    repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0060, 0, 0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0, 16'h0060, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0060, 0, 0, 0, 1, 16'h1234);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 16'h00A1, 16'hBEEF, 2'b10, 0, 0);
    repeat (2) step(0, 0, 0, 1, 0, 16'h00A1, 16'hBEEF, 2'b10, 0, 0);
    step(0, 0, 0, 1, 0, 16'h00A1, 16'hBEEF, 2'b10, 1, 16'h5555);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 1, 1, 0, 16'h0100, 16'h0200, 0, 0, 1, 16'hA5A5);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0010, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0020, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 16'h0020, 0, 0, 1, 16'h0BAD);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0300, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0300, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 16'h0300, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hDEAD);
    step(0, 1, 0, 0, 16'h0300, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 16'h0300, 0, 0, 0, 1, 16'h4321);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 16'hFFFF);
    ia_act = 0; da_act = 0; d_r = 0; d_w = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!ia_act && $urandom_range(0, 2) == 0) ia_act = 1;
      if (!da_act && $urandom_range(0, 2) == 0) begin
        da_act = 1;
        d_w = 1'($urandom_range(0, 1));
        d_r = !d_w || 1'($urandom_range(0, 1));
      end
      step($urandom_range(0, 99) == 0, ia_act, da_act && d_r, da_act && d_w,
           16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom),
           $urandom_range(0, 2) == 0, 16'($urandom));
      if (e_ir[0]) ia_act = 0;
      if (e_dr[0]) da_act = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
